ser2par_align: RTL and testbench

- Parametrised successor of the fixed 10-bit ser2par deserializer.
- Deserializes an LSB-first serial stream into WIDTH-bit words, with optional polarity inversion.
- Finds word boundaries from a comma pattern, matched in either disparity, and flags each word with a one-cycle valid strobe.
- Sits in the receive path between the serial line and the 8b/10b decoder, in the same clock domain as the recovered-clock receive logic.

---
 rtl/ser2par_align.sv | 179 +++++++++++++++++
 tb/tb_ser2par_align.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_align.sv
// ser2par_align: LSB-first serial-to-parallel deserializer with comma-based
// word alignment, optional polarity inversion and lock tracking.
module ser2par_align #(
  parameter int unsigned      WIDTH    = 10,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(10'h17C),
  parameter int unsigned      MAX_MISS = 4
) (
  input  logic             CRC_CKL,
  input  logic             RESET,
  input  logic             data_in,
  input  logic             RXPOL,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             comma_det,
  output logic             locked,
  output logic             align_err
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam int unsigned MISS_W = (MAX_MISS > 0) ? $clog2(MAX_MISS + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'((MAX_MISS > 0) ? (MAX_MISS - 1) : 0);
  localparam bit                LOSS_EN    = (MAX_MISS > 0);

  typedef enum logic [0:0] {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } state_t;

  // State and datapath registers
  state_t             r_state;
  logic [WIDTH-1:0]   r_sh;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic [MISS_W-1:0]  r_miss;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;
  logic               r_comma;
  logic               r_locked;
  logic               r_align_err;

  // Combinational decisions for the current edge
  state_t             w_next_state;
  logic               w_bit;
  logic [WIDTH-1:0]   w_sh_next;
  logic               w_fill_done;
  logic               w_match;
  logic               w_boundary;
  logic               w_miss_out;
  logic               w_emit;
  logic               w_comma;
  logic               w_realign;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [MISS_W-1:0]  w_miss_next;
  logic               w_locked_next;

  // Incoming bit after polarity correction, and the shifter value it produces
  always_comb begin
    w_bit       = data_in ^ RXPOL;
    w_sh_next   = {w_bit, r_sh[WIDTH-1:1]};
    // The WIDTH-th bit since reset is the first that completes a full word
    w_fill_done = (r_fill >= FILL_LAST);
    w_match     = w_fill_done && ((w_sh_next == COMMA) || (w_sh_next == ~COMMA));
    w_boundary  = (r_state == S_LOCKED) && (r_cnt == LAST_BIT);
    w_miss_out  = LOSS_EN && (r_miss == MISS_LIMIT);
  end

  // FSM state register
  always_ff @(posedge CRC_CKL) begin
    if (RESET) begin
      r_state <= S_UNLOCKED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: lock on any comma, drop lock after too many comma-less boundaries
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_UNLOCKED: begin
        if (w_match) begin
          w_next_state = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_boundary && !w_match && w_miss_out) begin
          w_next_state = S_UNLOCKED;
        end
      end
      default: w_next_state = S_UNLOCKED;
    endcase
  end

  // FSM outputs: word strobe, comma flag, realignment and counter updates
  always_comb begin
    w_emit      = 1'b0;
    w_comma     = 1'b0;
    w_realign   = 1'b0;
    w_cnt_next  = r_cnt;
    w_miss_next = r_miss;
    case (r_state)
      S_UNLOCKED: begin
        w_cnt_next  = '0;
        w_miss_next = '0;
        if (w_match) begin
          w_emit  = 1'b1;
          w_comma = 1'b1;
        end
      end
      S_LOCKED: begin
        if (w_match && !w_boundary) begin
          // Comma seen off the current boundary: restart the word here
          w_emit      = 1'b1;
          w_comma     = 1'b1;
          w_realign   = 1'b1;
          w_cnt_next  = '0;
          w_miss_next = '0;
        end else if (w_boundary) begin
          w_emit     = 1'b1;
          w_comma    = w_match;
          w_cnt_next = '0;
          if (w_match || w_miss_out) begin
            w_miss_next = '0;
          end else if (LOSS_EN) begin
            w_miss_next = r_miss + MISS_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_next  = '0;
        w_miss_next = '0;
      end
    endcase
    w_locked_next = (w_next_state == S_LOCKED);
  end

  // Shifter, fill guard, counters and registered outputs
  always_ff @(posedge CRC_CKL) begin
    if (RESET) begin
      r_sh        <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_miss      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_comma     <= 1'b0;
      r_locked    <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_sh <= w_sh_next;
      if (r_fill != FILL_FULL) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      r_cnt  <= w_cnt_next;
      r_miss <= w_miss_next;
      if (w_emit) begin
        r_data <= w_sh_next;
      end
      r_valid     <= w_emit;
      r_comma     <= w_comma;
      r_align_err <= w_realign;
      r_locked    <= w_locked_next;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign comma_det  = r_comma;
  assign locked     = r_locked;
  assign align_err  = r_align_err;

endmodule

// File: tb/tb_ser2par_align.sv
// Scoreboard bench for ser2par_align: a 10-bit default instance and an
// 8-bit instance, with expected strobes queued ahead of the stimulus.
module tb_ser2par_align;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic din  = 1'b0;
  logic pol  = 1'b0;
  logic rst8 = 1'b1;
  logic din8 = 1'b0;

  logic [9:0] dout;
  logic       dv, cd, lk, ae;
  logic [7:0] dout8;
  logic       dv8, cd8, lk8, ae8;

  typedef struct {
    logic [9:0] data;
    logic       cd;
    logic       ae;
    logic       lk;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_edge = 0;

  ser2par_align u_dut (
    .CRC_CKL   (clk),
    .RESET     (rst),
    .data_in   (din),
    .RXPOL     (pol),
    .data_out  (dout),
    .data_valid(dv),
    .comma_det (cd),
    .locked    (lk),
    .align_err (ae)
  );

  ser2par_align #(
    .WIDTH   (8),
    .COMMA   (8'hBC),
    .MAX_MISS(4)
  ) u_dut8 (
    .CRC_CKL   (clk),
    .RESET     (rst8),
    .data_in   (din8),
    .RXPOL     (1'b0),
    .data_out  (dout8),
    .data_valid(dv8),
    .comma_det (cd8),
    .locked    (lk8),
    .align_err (ae8)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic b, input logic b8);
    din  = b;
    din8 = b8;
    @(posedge clk);
    n_edge++;
    #1;
  endtask

  task automatic send(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) tick(w[i], 1'b0);
  endtask

  task automatic send8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) tick(1'b0, w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic expect_w(input logic [9:0] d, input logic c, input logic a,
                          input logic l, input int dt);
    exp_t e;
    e.data = d; e.cd = c; e.ae = a; e.lk = l; e.at = n_edge + dt;
    q.push_back(e);
  endtask

  task automatic expect8(input logic [7:0] d, input logic c, input logic a,
                         input logic l, input int dt);
    exp_t e;
    e.data = {2'b00, d}; e.cd = c; e.ae = a; e.lk = l; e.at = n_edge + dt;
    q8.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Compares every strobe of one instance against the head of its queue
  task automatic mon_one(input string name, input logic v, input logic [9:0] d,
                         input logic c, input logic a, input logic l, inout exp_t qq[$]);
    exp_t e;
    if (v) begin
      n_cmp++;
      if (qq.size() == 0) begin
        n_bad++;
        $display("FAIL %s unexpected strobe: data=%h cd=%b ae=%b lk=%b edge=%0d",
                 name, d, c, a, l, n_edge);
      end else begin
        e = qq.pop_front();
        if (d !== e.data || c !== e.cd || a !== e.ae || l !== e.lk || n_edge != e.at) begin
          n_bad++;
          $display("FAIL %s strobe: got data=%h cd=%b ae=%b lk=%b edge=%0d want data=%h cd=%b ae=%b lk=%b edge=%0d",
                   name, d, c, a, l, n_edge, e.data, e.cd, e.ae, e.lk, e.at);
        end
      end
    end else if (c || a) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s flag without strobe: cd=%b ae=%b edge=%0d", name, c, a, n_edge);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_one("dut10", dv, dout, cd, ae, lk, q);
      mon_one("dut8", dv8, {2'b00, dout8}, cd8, ae8, lk8, q8);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    do_reset();
    check("rst_data", 32'(dout), 32'h0);
    check("rst_valid", 32'(dv), 32'h0);
    check("rst_comma", 32'(cd), 32'h0);
    check("rst_locked", 32'(lk), 32'h0);
    check("rst_aerr", 32'(ae), 32'h0);

    // Lock on comma, then two data words
    expect_w(10'h17C, 1'b1, 1'b0, 1'b1, 10);
    expect_w(10'h0AA, 1'b0, 1'b0, 1'b1, 20);
    expect_w(10'h155, 1'b0, 1'b0, 1'b1, 30);
    send(10'h17C, 10);
    send(10'h0AA, 10);
    send(10'h155, 10);
    check("t1_locked", 32'(lk), 32'h1);
    do_reset();
    check("t1_qempty", 32'(q.size()), 32'h0);

    // Inverted line, then opposite-disparity comma sent raw
    pol = 1'b1;
    expect_w(10'h17C, 1'b1, 1'b0, 1'b1, 10);
    expect_w(10'h0AA, 1'b0, 1'b0, 1'b1, 20);
    send(10'h283, 10);
    send(10'h355, 10);
    do_reset();
    pol = 1'b0;
    expect_w(10'h283, 1'b1, 1'b0, 1'b1, 10);
    send(10'h283, 10);
    do_reset();
    check("t2_qempty", 32'(q.size()), 32'h0);

    // Misaligned comma while locked
    expect_w(10'h17C, 1'b1, 1'b0, 1'b1, 10);
    expect_w(10'h3E5, 1'b0, 1'b0, 1'b1, 20);
    expect_w(10'h17C, 1'b1, 1'b1, 1'b1, 23);
    expect_w(10'h0AA, 1'b0, 1'b0, 1'b1, 33);
    send(10'h17C, 10);
    send(10'h005, 3);
    send(10'h17C, 10);
    send(10'h0AA, 10);
    do_reset();
    check("t3_qempty", 32'(q.size()), 32'h0);

    // Lock loss after four comma-less boundaries, relock on next comma
    expect_w(10'h17C, 1'b1, 1'b0, 1'b1, 10);
    expect_w(10'h0AA, 1'b0, 1'b0, 1'b1, 20);
    expect_w(10'h155, 1'b0, 1'b0, 1'b1, 30);
    expect_w(10'h0AA, 1'b0, 1'b0, 1'b1, 40);
    expect_w(10'h155, 1'b0, 1'b0, 1'b0, 50);
    expect_w(10'h17C, 1'b1, 1'b0, 1'b1, 80);
    send(10'h17C, 10);
    send(10'h0AA, 10);
    send(10'h155, 10);
    send(10'h0AA, 10);
    send(10'h155, 10);
    check("t4_unlocked", 32'(lk), 32'h0);
    send(10'h0AA, 10);
    send(10'h155, 10);
    send(10'h17C, 10);
    do_reset();
    check("t4_qempty", 32'(q.size()), 32'h0);

    // Reset mid-word discards the partial word
    send(10'h17C, 9);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    expect_w(10'h17C, 1'b1, 1'b0, 1'b1, 10);
    send(10'h17C, 10);
    do_reset();
    // Comma's upper 8 bits over a zeroed shifter must not match before fill
    send(10'h05F, 10);
    check("t5_guard_locked", 32'(lk), 32'h0);
    do_reset();
    check("t5_qempty", 32'(q.size()), 32'h0);

    // 8-bit instance with its own comma
    rst = 1'b1;
    rst8 = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst8_data", 32'(dout8), 32'h0);
    check("rst8_locked", 32'(lk8), 32'h0);
    rst8 = 1'b0;
    expect8(8'hBC, 1'b1, 1'b0, 1'b1, 8);
    expect8(8'h12, 1'b0, 1'b0, 1'b1, 16);
    send8(8'hBC);
    send8(8'h12);
    check("t6_data", 32'(dout8), 32'h12);
    rst8 = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("t6_qempty", 32'(q8.size()), 32'h0);
    check("t6_main_qempty", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
